// File: rtl/zion_rvi_bj_redirect_ctrl_pkg.sv
// Shared RVI helpers for the branch/jump redirect controller: state enum,
// resolution record and the fall-through / mispredict compare.
package ZionRiscvIsaLib;

    localparam int XLEN_MAX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } bjRedirState_e;

    // Fields are held at the widest datapath; narrower configs zero-extend in.
    typedef struct packed {
        logic [XLEN_MAX-1:0] resPc;
        logic                bjEn;
        logic [XLEN_MAX-1:0] tgtAddr;
        logic [1:0]          linkOffset;
        logic                predTaken;
        logic [XLEN_MAX-1:0] predTgt;
    } bjRes_t;

    typedef struct packed {
        logic                mispred;
        logic [XLEN_MAX-1:0] pc;
    } bjCmp_t;

    // Only a 2-byte link offset is honoured; every other code means +4.
    function automatic bjCmp_t bjCompare(input bjRes_t r);
        bjCmp_t              c;
        logic [XLEN_MAX-1:0] fallThru;
        fallThru  = r.resPc + ((r.linkOffset == 2'b01) ? XLEN_MAX'(2) : XLEN_MAX'(4));
        c.pc      = r.bjEn ? r.tgtAddr : fallThru;
        c.mispred = (r.predTaken != r.bjEn) | (r.bjEn & (r.predTgt != r.tgtAddr));
        return c;
    endfunction

endpackage

// File: rtl/zion_rvi_bj_redirect_ctrl_perfcnt.sv
// Accepted-resolution and mispredict counters, both free-running and wrapping.
module zion_rvi_bj_redirect_ctrl_perfcnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bjInc,
    input  logic             i_misInc,
    output logic [CNT_W-1:0] o_bjCnt,
    output logic [CNT_W-1:0] o_mispredCnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_bjCnt      <= '0;
            o_mispredCnt <= '0;
        end else begin
            if (i_bjInc)  o_bjCnt      <= o_bjCnt + CNT_W'(1);
            if (i_misInc) o_mispredCnt <= o_mispredCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/zion_rvi_bj_redirect_ctrl.sv
// Branch/jump mispredict redirect: one corrected-PC handshake to fetch plus a
// flush drain window. Perf counters exist only with ZION_RVI_BJ_REDIR_PERFCNT_EN.
module zion_rvi_bj_redirect_ctrl
    import ZionRiscvIsaLib::*;
#(
    parameter int RV64      = 0,
    parameter int CPU_WIDTH = 32*(RV64+1),
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_resVld,
    output logic                 o_resRdy,
    input  logic [CPU_WIDTH-1:0] i_resPc,
    input  logic                 i_bjEn,
    input  logic [CPU_WIDTH-1:0] i_tgtAddr,
    input  logic [1:0]           i_linkOffset,
    input  logic                 i_predTaken,
    input  logic [CPU_WIDTH-1:0] i_predTgt,
    output logic                 o_redirVld,
    input  logic                 i_redirRdy,
    output logic [CPU_WIDTH-1:0] o_redirPc,
    output logic                 o_flush,
    output logic [CNT_W-1:0]     o_bjCnt,
    output logic [CNT_W-1:0]     o_mispredCnt
);

    bjRedirState_e state;
    logic [3:0]    drainCnt;
    bjRes_t        res;
    bjCmp_t        cmp;
    logic          accept;

    assign res.resPc      = XLEN_MAX'(i_resPc);
    assign res.bjEn       = i_bjEn;
    assign res.tgtAddr    = XLEN_MAX'(i_tgtAddr);
    assign res.linkOffset = i_linkOffset;
    assign res.predTaken  = i_predTaken;
    assign res.predTgt    = XLEN_MAX'(i_predTgt);
    assign cmp            = bjCompare(res);

    // Truncating the wide sum back to CPU_WIDTH is what gives the address wrap.
    generate
        if (CPU_WIDTH < XLEN_MAX) begin : gNarrow
            logic unusedHi;
            assign unusedHi = ^cmp.pc[XLEN_MAX-1:CPU_WIDTH];
        end
    endgenerate

    assign o_resRdy = (state == IDLE);
    assign accept   = i_resVld & o_resRdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drainCnt   <= '0;
            o_redirVld <= 1'b0;
            o_redirPc  <= '0;
            o_flush    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && cmp.mispred) begin
                        state      <= REDIR;
                        o_redirPc  <= cmp.pc[CPU_WIDTH-1:0];
                        o_redirVld <= 1'b1;
                        o_flush    <= 1'b1;
                    end
                end
                REDIR: begin
                    if (i_redirRdy) begin
                        o_redirVld <= 1'b0;
                        if (DRAIN_CYC == 0) begin
                            state   <= IDLE;
                            o_flush <= 1'b0;
                        end else begin
                            state    <= DRAIN;
                            drainCnt <= 4'(DRAIN_CYC);
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt == 4'd1) begin
                        state   <= IDLE;
                        o_flush <= 1'b0;
                    end
                    drainCnt <= drainCnt - 4'd1;
                end
                default: begin
                    state      <= IDLE;
                    o_redirVld <= 1'b0;
                    o_flush    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ZION_RVI_BJ_REDIR_PERFCNT_EN
    zion_rvi_bj_redirect_ctrl_perfcnt #(.CNT_W(CNT_W)) uPerfCnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_bjInc     (accept),
        .i_misInc    (accept & cmp.mispred),
        .o_bjCnt     (o_bjCnt),
        .o_mispredCnt(o_mispredCnt)
    );
`else
    assign o_bjCnt      = '0;
    assign o_mispredCnt = '0;
`endif

endmodule

// File: tb/tb_zion_rvi_bj_redirect_ctrl.sv
// Directed bench for zion_rvi_bj_redirect_ctrl: cycle compare against a
// transaction-level model plus hand-computed literal checks.
module tb_zion_rvi_bj_redirect_ctrl;

    localparam int W     = 32;
    localparam int DRAIN = 2;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          resVld = 1'b0;
    logic          resRdy;
    logic [W-1:0]  resPc = '0;
    logic          bjEn = 1'b0;
    logic [W-1:0]  tgtAddr = '0;
    logic [1:0]    linkOffset = 2'b10;
    logic          predTaken = 1'b0;
    logic [W-1:0]  predTgt = '0;
    logic          redirVld;
    logic          redirRdy = 1'b1;
    logic [W-1:0]  redirPc;
    logic          flush;
    logic [CW-1:0] bjCnt;
    logic [CW-1:0] misCnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    zion_rvi_bj_redirect_ctrl #(.RV64(0), .CPU_WIDTH(W), .DRAIN_CYC(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_resVld(resVld), .o_resRdy(resRdy),
        .i_resPc(resPc), .i_bjEn(bjEn), .i_tgtAddr(tgtAddr), .i_linkOffset(linkOffset),
        .i_predTaken(predTaken), .i_predTgt(predTgt),
        .o_redirVld(redirVld), .i_redirRdy(redirRdy), .o_redirPc(redirPc), .o_flush(flush),
        .o_bjCnt(bjCnt), .o_mispredCnt(misCnt)
    );

    // Model: a pending redirect, then a countdown of flush-only cycles.
    logic         mBusy = 1'b0;
    logic         mRedir = 1'b0;
    int           mDrainLeft = 0;
    logic [W-1:0] mPc = '0;
    int unsigned  mBj = 0;
    int unsigned  mMis = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 0; mRedir = 0; mDrainLeft = 0; mPc = '0; mBj = 0; mMis = 0;
        end else if (!mBusy) begin
            if (resVld) begin
                logic [W-1:0] want;
                logic         wrong;
                want  = bjEn ? tgtAddr : resPc + ((linkOffset == 2'b01) ? 32'd2 : 32'd4);
                wrong = (predTaken != bjEn) || (bjEn && predTgt != tgtAddr);
                mBj++;
                if (wrong) begin
                    mMis++; mBusy = 1; mRedir = 1; mPc = want;
                end
            end
        end else if (mRedir) begin
            if (redirRdy) begin
                mRedir = 0; mDrainLeft = DRAIN;
                if (DRAIN == 0) mBusy = 0;
            end
        end else begin
            mDrainLeft--;
            if (mDrainLeft == 0) mBusy = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("resRdy", 64'(resRdy), 64'(!mBusy));
        chk("redirVld", 64'(redirVld), 64'(mRedir));
        chk("flush", 64'(flush), 64'(mBusy));
        chk("redirPc", 64'(redirPc), 64'(mPc));
`ifdef ZION_RVI_BJ_REDIR_PERFCNT_EN
        chk("bjCnt", 64'(bjCnt), 64'(mBj));
        chk("misCnt", 64'(misCnt), 64'(mMis));
`else
        chk("bjCnt", 64'(bjCnt), 64'd0);
        chk("misCnt", 64'(misCnt), 64'd0);
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] pc, input logic bj, input logic [W-1:0] tgt,
                         input logic [1:0] lo, input logic pt, input logic [W-1:0] ptgt);
        resVld = 1'b1; resPc = pc; bjEn = bj; tgtAddr = tgt;
        linkOffset = lo; predTaken = pt; predTgt = ptgt;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!resRdy && n < 50) begin step(1); n++; end
        chk("idleTimeout", 64'(resRdy), 64'd1);
    endtask

    int vldN, flN;
    logic expCnt;

    initial begin
`ifdef ZION_RVI_BJ_REDIR_PERFCNT_EN
        expCnt = 1'b1;
`else
        expCnt = 1'b0;
`endif
        #2;
        chk("rstRdy", 64'(resRdy), 64'd1);
        chk("rstVld", 64'(redirVld), 64'd0);
        chk("rstPc", 64'(redirPc), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // 1: correct taken prediction
        drive(32'h100, 1, 32'h200, 2'b10, 1, 32'h200);
        step(1); resVld = 0;
        chk("t1Vld", 64'(redirVld), 64'd0);
        chk("t1Flush", 64'(flush), 64'd0);
        chk("t1Bj", 64'(bjCnt), expCnt ? 64'd1 : 64'd0);
        chk("t1Mis", 64'(misCnt), 64'd0);

        // back-to-back correct not-taken resolutions, one per cycle
        drive(32'h10, 0, 32'h0, 2'b01, 0, 32'h0);
        step(1);
        drive(32'h20, 0, 32'h0, 2'b11, 0, 32'h0);
        step(1); resVld = 0;
        chk("b2bBj", 64'(bjCnt), expCnt ? 64'd3 : 64'd0);

        // 2: direction mispredict, fall-through +4
        drive(32'h100, 0, 32'h0, 2'b10, 1, 32'h0);
        step(1); resVld = 0;
        chk("t2Vld", 64'(redirVld), 64'd1);
        chk("t2Pc", 64'(redirPc), 64'h104);
        chk("t2Flush", 64'(flush), 64'd1);
        waitIdle();

        // 3: target mispredict, with a resolution held during REDIR that must wait
        redirRdy = 0;
        drive(32'h100, 1, 32'h200, 2'b10, 1, 32'h300);
        step(1);
        chk("t3Pc", 64'(redirPc), 64'h200);
        chk("t3Mis", 64'(misCnt), expCnt ? 64'd2 : 64'd0);
        drive(32'h40, 0, 32'h0, 2'b00, 1, 32'h0);
        step(2);
        chk("t3HoldRdy", 64'(resRdy), 64'd0);
        chk("t3HoldPc", 64'(redirPc), 64'h200);
        redirRdy = 1;
        waitIdle();
        step(1); resVld = 0;
        chk("t3LatePc", 64'(redirPc), 64'h44);
        waitIdle();

        // 4: backpressure for 3 cycles then drain window
        drive(32'h500, 1, 32'h800, 2'b10, 0, 32'h0);
        step(1); resVld = 0;
        vldN = 0; flN = 0;
        for (int i = 0; i < 10; i++) begin
            redirRdy = (i == 3);
            @(negedge clk);
            vldN += int'(redirVld);
            flN  += int'(flush);
            if (redirVld) chk("t4PcHeld", 64'(redirPc), 64'h800);
            @(posedge clk); #1;
        end
        chk("t4VldCycles", 64'(vldN), 64'd4);
        chk("t4FlushCycles", 64'(flN), 64'(4 + DRAIN));
        chk("t4Rdy", 64'(resRdy), 64'd1);
        redirRdy = 1;

        // 5: fall-through wraps to zero
        drive(32'hFFFF_FFFE, 0, 32'h0, 2'b01, 1, 32'h0);
        step(1); resVld = 0;
        chk("t5Pc", 64'(redirPc), 64'h0);
        waitIdle();

        // 6: reset in REDIR drops everything at once
        redirRdy = 0;
        drive(32'h700, 0, 32'h0, 2'b10, 1, 32'h0);
        step(1); resVld = 0;
        chk("t6PreVld", 64'(redirVld), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6Vld", 64'(redirVld), 64'd0);
        chk("t6Flush", 64'(flush), 64'd0);
        chk("t6Rdy", 64'(resRdy), 64'd1);
        chk("t6Cnt", 64'(bjCnt), 64'd0);
        step(1);
        rst_n = 1'b1;
        redirRdy = 1;
        step(4);
        chk("t6NoRedir", 64'(redirVld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
